// File: rtl/gesture_pkg.sv
// Shared types for the button gesture decoder: FSM states, gesture codes and
// a small helper used to size the shared cycle counter.
package gesture_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        GAP,
        WAIT_RELEASE
    } state_t;

    typedef enum logic [1:0] {
        NONE,
        SHORT,
        LONG,
        DOUBLE
    } gesture_t;

    function automatic int max_ticks(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debouncer.sv
// Level debouncer: the output follows the input only after the input has
// disagreed with it for BOUNCE_TICKS consecutive cycles.
module debouncer #(
    parameter int BOUNCE_TICKS = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic bouncy_in,
    output logic debounced_out
);

    localparam int CW = $clog2(BOUNCE_TICKS) + 1;
    localparam logic [CW-1:0] LAST = CW'(BOUNCE_TICKS - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            debounced_out <= 1'b0;
            cnt           <= '0;
        end else if (bouncy_in == debounced_out) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            debounced_out <= bouncy_in;
            cnt           <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/button_gesture_decoder.sv
// Classifies debounced pushbutton activity into short, long and double press
// pulses using a four-state FSM and one shared, saturating cycle counter.
module button_gesture_decoder
    import gesture_pkg::*;
#(
    parameter int BOUNCE_TICKS = 10,
    parameter int LONG_TICKS   = 1000,
    parameter int GAP_TICKS    = 300
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic pressed,
    output logic short_press,
    output logic long_press,
    output logic double_press
);

    localparam int CNT_W = $clog2(max_ticks(LONG_TICKS, GAP_TICKS)) + 1;
    // Counter starts one cycle after the edge that triggered it, hence the -2.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 2);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 2);

    logic sync1, sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
        end
    end

    debouncer #(
        .BOUNCE_TICKS(BOUNCE_TICKS)
    ) u_debouncer (
        .clk          (clk),
        .rst          (rst),
        .bouncy_in    (sync2),
        .debounced_out(pressed)
    );

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
    gesture_t         gesture_next;
    // Set when a gap expires; a press already up at that point must be released first.
    logic             rearm_block, rearm_block_next;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next       = state;
        cnt_inc          = (cnt == '1) ? cnt : cnt + CNT_W'(1);
        cnt_next         = cnt;
        rearm_block_next = rearm_block;
        gesture_next     = NONE;

        case (state)
            IDLE: begin
                if (!pressed) begin
                    rearm_block_next = 1'b0;
                end else if (!rearm_block) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_next = GAP;
                    cnt_next   = '0;
                end else if (cnt == LONG_LAST) begin
                    gesture_next = LONG;
                    state_next   = WAIT_RELEASE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            GAP: begin
                if (pressed) begin
                    gesture_next = DOUBLE;
                    state_next   = WAIT_RELEASE;
                end else if (cnt == GAP_LAST) begin
                    gesture_next     = SHORT;
                    state_next       = IDLE;
                    rearm_block_next = 1'b1;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            WAIT_RELEASE: begin
                if (!pressed) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            rearm_block  <= 1'b0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            rearm_block  <= rearm_block_next;
            short_press  <= (gesture_next == SHORT);
            long_press   <= (gesture_next == LONG);
            double_press <= (gesture_next == DOUBLE);
        end
    end

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Scoreboard bench: stimulus queues the expected pressed edges and gesture
// pulses with their cycle stamps; a negedge monitor pops and compares them.
module tb_button_gesture_decoder;

    typedef enum int {EV_RISE, EV_FALL, EV_SHORT, EV_LONG, EV_DOUBLE} ev_t;
    typedef struct {
        ev_t kind;
        int  cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic button;
    logic pressed, short_press, long_press, double_press;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    int   base;
    logic prev_pressed = 1'b0;

    button_gesture_decoder #(
        .BOUNCE_TICKS(4),
        .LONG_TICKS  (20),
        .GAP_TICKS   (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .button      (button),
        .pressed     (pressed),
        .short_press (short_press),
        .long_press  (long_press),
        .double_press(double_press)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic expect_ev(input ev_t k, input int c);
        exp_q.push_back('{kind: k, cyc: c});
    endtask

    task automatic observe(input ev_t k);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({"unexpected_", k.name()}, cyc, -1);
            return;
        end
        e = exp_q.pop_front();
        check({"kind_", e.kind.name()}, int'(k), int'(e.kind));
        check({"cycle_", e.kind.name()}, cyc, e.cyc);
    endtask

    // Pressed edges are reported before pulses within a cycle; expectations follow that order.
    always @(negedge clk) begin
        if (pressed !== prev_pressed) observe(pressed ? EV_RISE : EV_FALL);
        prev_pressed <= pressed;
        if (short_press)  observe(EV_SHORT);
        if (long_press)   observe(EV_LONG);
        if (double_press) observe(EV_DOUBLE);
    end

    task automatic drive(input logic v, input int n);
        button = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_pressed"}, int'(pressed), 0);
        check({tag, "_short"},   int'(short_press), 0);
        check({tag, "_long"},    int'(long_press), 0);
        check({tag, "_double"},  int'(double_press), 0);
    endtask

    initial begin
        rst    = 1'b1;
        button = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Bounce: 2-cycle toggles never pass the 4-cycle window; the final hold does.
        base = cyc;
        expect_ev(EV_RISE, base + 18);
        expect_ev(EV_LONG, base + 38);
        expect_ev(EV_FALL, base + 58);
        for (int i = 0; i < 6; i++) drive(logic'(i % 2 == 0), 2);
        drive(1'b1, 40);
        drive(1'b0, 40);

        // Long press: held 50 cycles.
        base = cyc;
        expect_ev(EV_RISE, base + 6);
        expect_ev(EV_LONG, base + 26);
        expect_ev(EV_FALL, base + 56);
        drive(1'b1, 50);
        drive(1'b0, 40);

        // Short press: 8 cycles, short pulse 10 cycles after the debounced fall.
        base = cyc;
        expect_ev(EV_RISE,  base + 6);
        expect_ev(EV_FALL,  base + 14);
        expect_ev(EV_SHORT, base + 24);
        drive(1'b1, 8);
        drive(1'b0, 40);

        // Double press: press 5, release 6, press 30.
        base = cyc;
        expect_ev(EV_RISE,   base + 6);
        expect_ev(EV_FALL,   base + 11);
        expect_ev(EV_RISE,   base + 17);
        expect_ev(EV_DOUBLE, base + 18);
        expect_ev(EV_FALL,   base + 47);
        drive(1'b1, 5);
        drive(1'b0, 6);
        drive(1'b1, 30);
        drive(1'b0, 40);

        // Gap of exactly 10: short wins, the long-held second press is ignored,
        // and a fresh press afterwards is decoded normally.
        base = cyc;
        expect_ev(EV_RISE,  base + 6);
        expect_ev(EV_FALL,  base + 11);
        expect_ev(EV_RISE,  base + 21);
        expect_ev(EV_SHORT, base + 21);
        expect_ev(EV_FALL,  base + 51);
        expect_ev(EV_RISE,  base + 66);
        expect_ev(EV_FALL,  base + 71);
        expect_ev(EV_SHORT, base + 81);
        drive(1'b1, 5);
        drive(1'b0, 10);
        drive(1'b1, 30);
        drive(1'b0, 15);
        drive(1'b1, 5);
        drive(1'b0, 40);

        // Reset 10 cycles into a hold, button kept down through reset release.
        base = cyc;
        expect_ev(EV_RISE, base + 6);
        expect_ev(EV_FALL, base + 17);
        expect_ev(EV_RISE, base + 24);
        expect_ev(EV_LONG, base + 44);
        expect_ev(EV_FALL, base + 66);
        drive(1'b1, 16);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_quiet("mid_reset");
        rst = 1'b0;
        repeat (42) @(negedge clk);
        drive(1'b0, 40);

        repeat (20) @(negedge clk);
        check("pending_expectations", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_gesture_decoder.md
BUTTON_GESTURE_DECODER -- requirements
Module: button_gesture_decoder

Interface
REQ-001 SHALL have parameter BOUNCE_TICKS, default 10: debounce stability window, in clk cycles.
REQ-002 SHALL have parameter LONG_TICKS, default 1000: hold time that qualifies a long press, in cycles; legal range is 2 or more.
REQ-003 SHALL have parameter GAP_TICKS, default 300: maximum release gap for a double press, in cycles; legal range is 2 or more.
REQ-004 SHALL have port clk, input, 1 bit: system clock.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port button, input, 1 bit: raw asynchronous bouncy pushbutton; 1 = pressed.
REQ-007 SHALL have port pressed, output, 1 bit: debounced button level.
REQ-008 SHALL have port short_press, output, 1 bit: one-cycle pulse for a single short press.
REQ-009 SHALL have port long_press, output, 1 bit: one-cycle pulse for a press held LONG_TICKS cycles.
REQ-010 SHALL have port double_press, output, 1 bit: one-cycle pulse for a second press inside the gap window.

Function
REQ-011 SHALL pass button through a 2-flop synchronizer before debouncing.
REQ-012 Debouncer SHALL change pressed only after the synchronized input has differed from pressed for BOUNCE_TICKS consecutive cycles; any glitch restarts the window.
REQ-013 FSM SHALL have states IDLE, HELD, GAP and WAIT_RELEASE, and one shared cycle counter wide enough for max(LONG_TICKS, GAP_TICKS).
REQ-014 IDLE: on the first cycle with pressed=1, go to HELD and clear the counter.
REQ-015 HELD: increment the counter each cycle; when LONG_TICKS cycles have elapsed since pressed rose, pulse long_press and go to WAIT_RELEASE.
REQ-016 HELD: if pressed falls first, go to GAP and clear the counter; no pulse is emitted.
REQ-017 GAP: if pressed rises before GAP_TICKS cycles have elapsed since it fell, pulse double_press on the next cycle and go to WAIT_RELEASE.
REQ-018 GAP: if GAP_TICKS cycles elapse with pressed=0, pulse short_press exactly GAP_TICKS cycles after the fall and go to IDLE.
REQ-019 WAIT_RELEASE: emit no events; on pressed=0, go to IDLE.
REQ-020 The second press of a double press SHALL never also produce long_press, however long it is held.
REQ-021 At most one of short_press, long_press and double_press SHALL be high in any cycle; each pulse SHALL last exactly one cycle.
REQ-022 A rise in the same cycle that the GAP count expires SHALL resolve as short_press; that rise SHALL NOT start a new gesture until pressed returns to 0 and rises again.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 On rst, pressed, short_press, long_press and double_press SHALL all be 0, the FSM SHALL be in IDLE, and the counter, synchronizer and debouncer state SHALL be 0.
REQ-025 Reset mid-gesture SHALL discard the gesture with no pulse.
REQ-026 A button held through reset release SHALL be treated as a new press once debounced.

Structure
REQ-027 The FSM state enum and a gesture_t enum (NONE, SHORT, LONG, DOUBLE) SHALL live in a shared package, gesture_pkg.
REQ-028 Debouncing SHALL reuse the existing debouncer sub-module (clk, rst, bouncy_in, debounced_out), with BOUNCE_TICKS passed through.
REQ-029 Counter width SHALL be derived with $clog2 of the larger tick parameter plus 1; the counter SHALL NOT wrap.

Verification
All scenarios use BOUNCE_TICKS=4, LONG_TICKS=20, GAP_TICKS=10.
REQ-030 Bounce test: button toggles every 2 cycles for 12 cycles, then holds at 1 -> pressed rises only after 4 stable cycles plus the synchronizer delay; it rises exactly once.
REQ-031 Short press: clean press of 8 cycles, then release -> short_press pulses once, exactly 10 cycles after pressed falls; no other pulse.
REQ-032 Long press: hold for 50 cycles -> long_press pulses exactly 20 cycles after pressed rises; nothing on release; short_press never fires.
REQ-033 Double press: press 5, release 6, press 30 cycles -> one double_press the cycle after the second pressed rise; no long_press or short_press.
REQ-034 Gap boundary: release gap of exactly 10 cycles -> short_press only; the second press is ignored until a fresh release and press.
REQ-035 Reset mid-HELD at cycle 10 with button still held -> no pulse; pressed goes 0; after reset, long_press pulses 20 cycles after the re-debounced rise.
